// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with HI/LO registers
//
// Purpose: implements MULT, MULTU, DIV, DIVU, MTHI and MTLO for the MIPS core.
//   Multiply is shift-add (or a single-cycle '*' when FAST_MUL=1); divide is
//   restoring, one quotient bit per cycle. Signs are stripped at acceptance
//   and reapplied in FIX.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-high; clears all state
//   active   - global enable; 0 freezes FSM, counter and hi/lo
//   start    - request; op and operands sampled when accepted
//   op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   rs_data  - operand A (multiplicand / dividend / MTHI-MTLO source)
//   rt_data  - operand B (multiplier / divisor)
//   busy     - high in MUL, DIV and FIX
//   done     - one-cycle pulse, hi/lo hold the result
//   hi, lo   - architectural HI/LO registers
module mult_div_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]     count;
  // Multiply: {upper partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;   // multiplicand or divisor magnitude
  logic              sq;     // result (quotient/product) negative
  logic              sr;     // remainder negative
  logic              is_div;
  logic              div_zero;

  logic              accept;
  logic              is_signed;
  logic [XLEN-1:0]   mag_rs;
  logic [XLEN-1:0]   mag_rt;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE) && (op <= OP_MTLO);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    mag_rs    = (is_signed && rs_data[XLEN-1]) ? -rs_data : rs_data;
    mag_rt    = (is_signed && rt_data[XLEN-1]) ? -rt_data : rt_data;
    fast_prod = (2*XLEN)'(mag_rs) * (2*XLEN)'(mag_rt);

    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);

    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = div_shift >= {1'b0, opnd};

    prod_fixed = sq ? -acc : acc;
    quo        = acc[XLEN-1:0];
    rem        = acc[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: state_next = FAST_MUL ? S_FIX : S_MUL;
            OP_DIV, OP_DIVU:   state_next = S_DIV;
            default:           state_next = S_DONE;
          endcase
        end else begin
          state_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (count == CW'(1)) state_next = S_FIX;
      S_FIX:        state_next = S_DONE;
      default:      state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (active) begin
      state <= state_next;
      if (accept) begin
        count    <= CW'(XLEN);
        sq       <= is_signed && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
        sr       <= is_signed && rs_data[XLEN-1];
        is_div   <= op[1];
        div_zero <= (rt_data == '0);
        case (op)
          OP_MULT, OP_MULTU: begin
            opnd <= mag_rs;
            acc  <= FAST_MUL ? fast_prod : {{XLEN{1'b0}}, mag_rt};
          end
          OP_DIV, OP_DIVU: begin
            opnd <= mag_rt;
            acc  <= {{XLEN{1'b0}}, mag_rs};
          end
          OP_MTHI: hi <= rs_data;
          default: lo <= rs_data;
        endcase
      end else begin
        case (state)
          S_MUL: begin
            acc   <= {mul_sum, acc[XLEN-1:1]};
            count <= count - CW'(1);
          end
          S_DIV: begin
            acc   <= {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc[XLEN-2:0], div_ge};
            count <= count - CW'(1);
          end
          S_FIX: begin
            if (is_div) begin
              // With a zero divisor the remainder equals |rs|, so the normal
              // sign fix restores the raw rs_data; only the quotient is forced.
              lo <= div_zero ? '1 : (sq ? -quo : quo);
              hi <= sr ? -rem : rem;
            end else begin
              {hi, lo} <= prod_fixed;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
